hci_pio_queue: RTL and testbench
================================

HCI_PIO_QUEUE -- requirements
Module: hci_pio_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 64, FIFO entries, power of two >= 2.
REQ-002 SHALL have parameter FIFO_WIDTH, default 64, entry width, integer multiple of CSR_WIDTH.
REQ-003 SHALL have parameter CSR_WIDTH, default 32, CSR port data width.
REQ-004 SHALL have parameter DIR, default 0, 0 = CSR-to-controller (command/TX), 1 = controller-to-CSR (RX/response).
REQ-005 SHALL have: clk_i  input  1  the single clock.
REQ-006 SHALL have: rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have: req_i  input  1  CSR port access request.
REQ-008 SHALL have: req_is_wr_i  input  1  access is a write.
REQ-009 SHALL have: wdata_i  input  CSR_WIDTH  CSR write data.
REQ-010 SHALL have: wr_ack_o  output  1  write acknowledge.
REQ-011 SHALL have: rd_ack_o  output  1  read acknowledge.
REQ-012 SHALL have: rdata_o  output  CSR_WIDTH  read data, valid with rd_ack_o.
REQ-013 SHALL have: ctrl_rvalid_o / ctrl_rready_i / ctrl_rdata_o  out/in/out  1/1/FIFO_WIDTH  controller pop port (DIR=0; outputs 0 when DIR=1).
REQ-014 SHALL have: ctrl_wvalid_i / ctrl_wready_o / ctrl_wdata_i  in/out/in  1/1/FIFO_WIDTH  controller push port (DIR=1; wready_o 0 when DIR=0).
REQ-015 SHALL have: thld_i  input  $clog2(DEPTH)+1  programmed threshold.
REQ-016 SHALL have: thld_o  output  $clog2(DEPTH)+1  effective threshold.
REQ-017 SHALL have: thld_trig_o / full_o / empty_o  output  1 each  threshold trigger, FIFO full, FIFO empty.
REQ-018 SHALL have: reg_rst_i / reg_rst_we_o / reg_rst_data_o  in/out/out  1 each  CSR soft-reset bit, its write-enable, its next value.
REQ-019 SHALL have: err_cnt_o  output  16  overflow/underflow error count.

Function
REQ-020 SHALL define BEATS = FIFO_WIDTH/CSR_WIDTH; beat counter 0..BEATS-1, wraps to 0 after last beat.
REQ-021 DIR=0: CSR write SHALL place wdata_i into beat slot (beat 0 = bits [CSR_WIDTH-1:0]); last beat pushes assembled entry; CSR reads acked with rdata_o=0, no state change.
REQ-022 DIR=1: CSR read SHALL return beat slot of FIFO head (beat 0 first); last beat pops entry; CSR writes acked, ignored.
REQ-023 Every req_i SHALL be acked exactly once, registered, in the next cycle; no stalls.
REQ-024 Push to full FIFO (DIR=0 last beat, or DIR=1 wvalid with wready_o=0 never pushes) SHALL drop data, still ack, increment error count; read from empty (DIR=1) SHALL return 0, not advance beat, increment error count.
REQ-025 ctrl_wready_o = !full_o; ctrl_rvalid_o = !empty_o; ctrl_rdata_o = head entry; transfer on valid&&ready.
REQ-026 Push visible on controller/CSR side the cycle after it is written; simultaneous push and pop SHALL leave count unchanged and be legal when full.
REQ-027 thld_o = min(max(thld_i,1), DEPTH); DIR=0: thld_trig_o = (DEPTH-count) >= thld_o; DIR=1: thld_trig_o = count >= thld_o; registered.
REQ-028 reg_rst_i=1 SHALL flush FIFO and beat counter in the next cycle and pulse reg_rst_we_o=1, reg_rst_data_o=0 for exactly one cycle; a req_i in the same cycle SHALL be acked with no effect.

Reset
REQ-029 rst_i SHALL clear FIFO, pointers, beat counter, err count; outputs: acks 0, rdata_o 0, empty_o 1, full_o 0, ctrl_rvalid_o 0, reg_rst_we_o 0, thld_trig_o 1 when DIR=0 else 0.
REQ-030 rst_i SHALL take priority over all other events, including reg_rst_i.

Configuration
REQ-031 With HCI_QUEUE_ERR_CNT_EN defined, err_cnt_o SHALL be a 16-bit saturating counter of REQ-024 events, cleared by rst_i and reg_rst_i.
REQ-032 Without HCI_QUEUE_ERR_CNT_EN, err_cnt_o SHALL be tied to 0 and no counter logic instantiated.

Verification
REQ-033 DIR=0, defaults: write 0x1111_1111 then 0x2222_2222 -> each acked next cycle; ctrl_rdata_o = 0x2222_2222_1111_1111, rvalid next cycle.
REQ-034 DIR=0, DEPTH=4: push 5 entries, no pops -> full_o after 4th, 5th dropped, err_cnt_o=1 (macro on) / 0 (off).
REQ-035 DIR=1: controller pushes 0xAAAA_BBBB_CCCC_DDDD -> CSR reads return 0xCCCC_DDDD, 0xAAAA_BBBB; empty_o=1 after second; third read returns 0, err_cnt_o+1.
REQ-036 DIR=1, thld_i=0 -> thld_o=1, thld_trig_o high after first push; thld_i=100, DEPTH=64 -> thld_o=64.
REQ-037 Mid-packet (after beat 0) assert reg_rst_i -> next cycle empty_o=1, beat counter 0, reg_rst_we_o one-cycle pulse with data 0.
REQ-038 Full FIFO, simultaneous push and pop -> count stays DEPTH, no error, data order preserved.

Source files
------------

// File: rtl/hci_pio_queue.sv
// PIO queue bridging a narrow CSR port and a wide controller FIFO port; DIR selects direction.
// Optional saturating error counter enabled by defining HCI_QUEUE_ERR_CNT_EN.
module hci_pio_queue #(
    parameter int DEPTH      = 64,
    parameter int FIFO_WIDTH = 64,
    parameter int CSR_WIDTH  = 32,
    parameter int DIR        = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      req_is_wr_i,
    input  logic [CSR_WIDTH-1:0]      wdata_i,
    output logic                      wr_ack_o,
    output logic                      rd_ack_o,
    output logic [CSR_WIDTH-1:0]      rdata_o,
    output logic                      ctrl_rvalid_o,
    input  logic                      ctrl_rready_i,
    output logic [FIFO_WIDTH-1:0]     ctrl_rdata_o,
    input  logic                      ctrl_wvalid_i,
    output logic                      ctrl_wready_o,
    input  logic [FIFO_WIDTH-1:0]     ctrl_wdata_i,
    input  logic [$clog2(DEPTH):0]    thld_i,
    output logic [$clog2(DEPTH):0]    thld_o,
    output logic                      thld_trig_o,
    output logic                      full_o,
    output logic                      empty_o,
    input  logic                      reg_rst_i,
    output logic                      reg_rst_we_o,
    output logic                      reg_rst_data_o,
    output logic [15:0]               err_cnt_o
);

    localparam int BEATS = FIFO_WIDTH / CSR_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [FIFO_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [FIFO_WIDTH-1:0] wbuf_q, wbuf_d;
    logic [FIFO_WIDTH-1:0] asm_entry, push_data, head;
    logic [CSR_WIDTH-1:0]  head_slot, rdata_q, rdata_d;
    logic [CW-1:0]         thld_eff;
    logic                  wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
    logic                  reg_rst_we_q, reg_rst_we_d;
    logic                  thld_trig_q, thld_trig_d;
    logic                  push, pop, err_inc, full, empty, last_beat;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign head      = mem_q[rptr_q];
    assign last_beat = (beat_q == LAST_BEAT);

    // Current beat selects which CSR-wide slot of the entry is written or read.
    always_comb begin
        asm_entry = wbuf_q;
        head_slot = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) begin
                asm_entry[b*CSR_WIDTH +: CSR_WIDTH] = wdata_i;
                head_slot = head[b*CSR_WIDTH +: CSR_WIDTH];
            end
        end
    end

    always_comb begin
        thld_eff = thld_i;
        if (thld_i == '0) begin
            thld_eff = CW'(1);
        end else if (thld_i > DEPTH_C) begin
            thld_eff = DEPTH_C;
        end
    end

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        beat_d       = beat_q;
        wbuf_d       = wbuf_q;
        push         = 1'b0;
        pop          = 1'b0;
        err_inc      = 1'b0;
        push_data    = (DIR == 0) ? asm_entry : ctrl_wdata_i;
        wr_ack_d     = req_i && req_is_wr_i;
        rd_ack_d     = req_i && !req_is_wr_i;
        rdata_d      = '0;
        reg_rst_we_d = reg_rst_i && !reg_rst_we_q;
        if (reg_rst_i) begin
            // Soft reset flushes everything; a concurrent CSR access is acked but dropped.
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            beat_d  = '0;
        end else begin
            if (DIR == 0) begin
                pop = ctrl_rready_i && !empty;
                if (req_i && req_is_wr_i) begin
                    wbuf_d = asm_entry;
                    if (last_beat) begin
                        beat_d = '0;
                        if (!full || pop) begin
                            push = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end else begin
                push = ctrl_wvalid_i && !full;
                if (req_i && !req_is_wr_i) begin
                    if (empty) begin
                        err_inc = 1'b1;
                    end else begin
                        rdata_d = head_slot;
                        if (last_beat) begin
                            pop    = 1'b1;
                            beat_d = '0;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
            end
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
        thld_trig_d = (DIR == 0) ? ((DEPTH_C - count_d) >= thld_eff) : (count_d >= thld_eff);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            beat_q       <= '0;
            wbuf_q       <= '0;
            wr_ack_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            rdata_q      <= '0;
            reg_rst_we_q <= 1'b0;
            thld_trig_q  <= (DIR == 0);
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            beat_q       <= beat_d;
            wbuf_q       <= wbuf_d;
            wr_ack_q     <= wr_ack_d;
            rd_ack_q     <= rd_ack_d;
            rdata_q      <= rdata_d;
            reg_rst_we_q <= reg_rst_we_d;
            thld_trig_q  <= thld_trig_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

`ifdef HCI_QUEUE_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || reg_rst_i) begin
            err_cnt_q <= '0;
        end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
    assign err_cnt_o      = '0;
`endif

    assign wr_ack_o       = wr_ack_q;
    assign rd_ack_o       = rd_ack_q;
    assign rdata_o        = rdata_q;
    assign ctrl_rvalid_o  = (DIR == 0) && !empty;
    assign ctrl_rdata_o   = (DIR == 0) ? head : '0;
    assign ctrl_wready_o  = (DIR != 0) && !full;
    assign thld_o         = thld_eff;
    assign thld_trig_o    = thld_trig_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign reg_rst_we_o   = reg_rst_we_q;
    assign reg_rst_data_o = 1'b0;

endmodule

// File: tb/tb_hci_pio_queue.sv
// Directed bench: a DIR=0 and a DIR=1 queue of depth 4, plus a default-depth DIR=1 queue for threshold clamping.
module tb_hci_pio_queue;

`ifdef HCI_QUEUE_ERR_CNT_EN
    localparam logic [63:0] ERR_ONE = 64'd1;
`else
    localparam logic [63:0] ERR_ONE = 64'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    // DIR=0 instance (CSR writes, controller pops)
    logic        req0 = 0, isWr0 = 0, rready0 = 0, wvalid0 = 0, regRst0 = 0;
    logic [31:0] wdata0 = 0, rdata0;
    logic [63:0] crdata0, cwdata0 = 0;
    logic        wrAck0, rdAck0, rvalid0, wready0, trig0, full0, empty0, rstWe0, rstData0;
    logic [2:0]  thldIn0 = 3'd1, thldOut0;
    logic [15:0] err0;

    hci_pio_queue #(.DEPTH(4), .FIFO_WIDTH(64), .CSR_WIDTH(32), .DIR(0)) u0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .req_is_wr_i(isWr0), .wdata_i(wdata0),
        .wr_ack_o(wrAck0), .rd_ack_o(rdAck0), .rdata_o(rdata0),
        .ctrl_rvalid_o(rvalid0), .ctrl_rready_i(rready0), .ctrl_rdata_o(crdata0),
        .ctrl_wvalid_i(wvalid0), .ctrl_wready_o(wready0), .ctrl_wdata_i(cwdata0),
        .thld_i(thldIn0), .thld_o(thldOut0), .thld_trig_o(trig0), .full_o(full0), .empty_o(empty0),
        .reg_rst_i(regRst0), .reg_rst_we_o(rstWe0), .reg_rst_data_o(rstData0), .err_cnt_o(err0));

    // DIR=1 instance (controller pushes, CSR reads)
    logic        req1 = 0, isWr1 = 0, rready1 = 0, wvalid1 = 0, regRst1 = 0;
    logic [31:0] wdata1 = 0, rdata1;
    logic [63:0] crdata1, cwdata1 = 0;
    logic        wrAck1, rdAck1, rvalid1, wready1, trig1, full1, empty1, rstWe1, rstData1;
    logic [2:0]  thldIn1 = 3'd0, thldOut1;
    logic [15:0] err1;

    hci_pio_queue #(.DEPTH(4), .FIFO_WIDTH(64), .CSR_WIDTH(32), .DIR(1)) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .req_is_wr_i(isWr1), .wdata_i(wdata1),
        .wr_ack_o(wrAck1), .rd_ack_o(rdAck1), .rdata_o(rdata1),
        .ctrl_rvalid_o(rvalid1), .ctrl_rready_i(rready1), .ctrl_rdata_o(crdata1),
        .ctrl_wvalid_i(wvalid1), .ctrl_wready_o(wready1), .ctrl_wdata_i(cwdata1),
        .thld_i(thldIn1), .thld_o(thldOut1), .thld_trig_o(trig1), .full_o(full1), .empty_o(empty1),
        .reg_rst_i(regRst1), .reg_rst_we_o(rstWe1), .reg_rst_data_o(rstData1), .err_cnt_o(err1));

    // Default-depth DIR=1 instance, only its threshold clamp is observed
    logic        tie2 = 0;
    logic [31:0] wdata2 = 0, rdata2;
    logic [63:0] crdata2, cwdata2 = 0;
    logic        wrAck2, rdAck2, rvalid2, wready2, trig2, full2, empty2, rstWe2, rstData2;
    logic [6:0]  thldIn2 = 7'd100, thldOut2;
    logic [15:0] err2;

    hci_pio_queue #(.DIR(1)) u2 (
        .clk_i(clk), .rst_i(rst), .req_i(tie2), .req_is_wr_i(tie2), .wdata_i(wdata2),
        .wr_ack_o(wrAck2), .rd_ack_o(rdAck2), .rdata_o(rdata2),
        .ctrl_rvalid_o(rvalid2), .ctrl_rready_i(tie2), .ctrl_rdata_o(crdata2),
        .ctrl_wvalid_i(tie2), .ctrl_wready_o(wready2), .ctrl_wdata_i(cwdata2),
        .thld_i(thldIn2), .thld_o(thldOut2), .thld_trig_o(trig2), .full_o(full2), .empty_o(empty2),
        .reg_rst_i(tie2), .reg_rst_we_o(rstWe2), .reg_rst_data_o(rstData2), .err_cnt_o(err2));

    // Counts one comparison and reports it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle CSR access on the selected instance; returns at the negedge where the ack is visible
    task automatic applyStimulus(input int unitSel, input logic isWrite, input logic [31:0] data);
        if (unitSel == 0) begin
            req0 = 1'b1; isWr0 = isWrite; wdata0 = data;
        end else begin
            req1 = 1'b1; isWr1 = isWrite; wdata1 = data;
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic writeEntry(input logic [31:0] hi, input logic [31:0] lo);
        applyStimulus(0, 1'b1, lo);
        applyStimulus(0, 1'b1, hi);
    endtask

    task automatic pushController(input logic [63:0] data);
        wvalid1 = 1'b1; cwdata1 = data;
        @(negedge clk);
        wvalid1 = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_empty0", {63'd0, empty0}, 64'd1);
        checkOutput("rst_full0", {63'd0, full0}, 64'd0);
        checkOutput("rst_rvalid0", {63'd0, rvalid0}, 64'd0);
        checkOutput("rst_trig0", {63'd0, trig0}, 64'd1);
        checkOutput("rst_trig1", {63'd0, trig1}, 64'd0);
        checkOutput("rst_acks0", {62'd0, wrAck0, rdAck0}, 64'd0);
        checkOutput("rst_rdata1", {32'd0, rdata1}, 64'd0);
        checkOutput("rst_we0", {63'd0, rstWe0}, 64'd0);
        checkOutput("rst_wready0", {63'd0, wready0}, 64'd0);
        checkOutput("rst_wready1", {63'd0, wready1}, 64'd1);

        // Two-beat assembly into one entry
        applyStimulus(0, 1'b1, 32'h1111_1111);
        checkOutput("beat0_ack", {63'd0, wrAck0}, 64'd1);
        checkOutput("beat0_novalid", {63'd0, rvalid0}, 64'd0);
        applyStimulus(0, 1'b1, 32'h2222_2222);
        checkOutput("beat1_ack", {63'd0, wrAck0}, 64'd1);
        checkOutput("beat1_rvalid", {63'd0, rvalid0}, 64'd1);
        checkOutput("beat1_rdata", crdata0, 64'h2222_2222_1111_1111);
        @(negedge clk);
        checkOutput("ack_drop", {63'd0, wrAck0}, 64'd0);
        applyStimulus(0, 1'b0, 32'h0);
        checkOutput("dir0_rd_ack", {63'd0, rdAck0}, 64'd1);
        checkOutput("dir0_rd_data", {32'd0, rdata0}, 64'd0);

        // Fill to full, then overflow
        writeEntry(32'hE000_0002, 32'h0000_0002);
        writeEntry(32'hE000_0003, 32'h0000_0003);
        checkOutput("three_notfull", {63'd0, full0}, 64'd0);
        writeEntry(32'hE000_0004, 32'h0000_0004);
        checkOutput("four_full", {63'd0, full0}, 64'd1);
        checkOutput("four_trig", {63'd0, trig0}, 64'd0);
        writeEntry(32'hE000_0005, 32'h0000_0005);
        checkOutput("ovf_ack", {63'd0, wrAck0}, 64'd1);
        checkOutput("ovf_err", {48'd0, err0}, ERR_ONE);
        checkOutput("ovf_head", crdata0, 64'h2222_2222_1111_1111);

        // Push and pop in the same cycle while full
        applyStimulus(0, 1'b1, 32'h0000_0006);
        rready0 = 1'b1;
        applyStimulus(0, 1'b1, 32'hE000_0006);
        rready0 = 1'b0;
        checkOutput("simul_full", {63'd0, full0}, 64'd1);
        checkOutput("simul_err", {48'd0, err0}, ERR_ONE);
        checkOutput("simul_head", crdata0, 64'hE000_0002_0000_0002);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] n;
            n = (i == 3) ? 32'd6 : 32'(i + 2);
            checkOutput($sformatf("drain%0d", i), crdata0, {32'hE000_0000 | n, n});
            rready0 = 1'b1;
            @(negedge clk);
            rready0 = 1'b0;
        end
        checkOutput("drain_empty", {63'd0, empty0}, 64'd1);
        checkOutput("drain_trig", {63'd0, trig0}, 64'd1);

        // Soft reset mid-packet with a concurrent write
        writeEntry(32'hE000_0007, 32'h0000_0007);
        applyStimulus(0, 1'b1, 32'h0000_0008);
        regRst0 = 1'b1;
        applyStimulus(0, 1'b1, 32'h0000_0BAD);
        regRst0 = 1'b0;
        checkOutput("srst_ack", {63'd0, wrAck0}, 64'd1);
        checkOutput("srst_empty", {63'd0, empty0}, 64'd1);
        checkOutput("srst_we", {63'd0, rstWe0}, 64'd1);
        checkOutput("srst_data", {63'd0, rstData0}, 64'd0);
        checkOutput("srst_err", {48'd0, err0}, 64'd0);
        @(negedge clk);
        checkOutput("srst_we_pulse", {63'd0, rstWe0}, 64'd0);
        writeEntry(32'hBBBB_0009, 32'hAAAA_0009);
        checkOutput("srst_beat0", crdata0, 64'hBBBB_0009_AAAA_0009);

        // DIR=1: controller push, CSR beat reads, underflow
        checkOutput("thld_min", {61'd0, thldOut1}, 64'd1);
        checkOutput("thld_max", {57'd0, thldOut2}, 64'd64);
        pushController(64'hAAAA_BBBB_CCCC_DDDD);
        checkOutput("rx_trig", {63'd0, trig1}, 64'd1);
        checkOutput("rx_notempty", {63'd0, empty1}, 64'd0);
        applyStimulus(1, 1'b1, 32'hFFFF_FFFF);
        checkOutput("rx_wr_ack", {63'd0, wrAck1}, 64'd1);
        applyStimulus(1, 1'b0, 32'h0);
        checkOutput("rx_rd0_ack", {63'd0, rdAck1}, 64'd1);
        checkOutput("rx_rd0", {32'd0, rdata1}, 64'hCCCC_DDDD);
        applyStimulus(1, 1'b0, 32'h0);
        checkOutput("rx_rd1", {32'd0, rdata1}, 64'hAAAA_BBBB);
        checkOutput("rx_empty", {63'd0, empty1}, 64'd1);
        checkOutput("rx_trig_low", {63'd0, trig1}, 64'd0);
        applyStimulus(1, 1'b0, 32'h0);
        checkOutput("rx_udf_ack", {63'd0, rdAck1}, 64'd1);
        checkOutput("rx_udf_data", {32'd0, rdata1}, 64'd0);
        checkOutput("rx_udf_err", {48'd0, err1}, ERR_ONE);

        // DIR=1 fill: wready drops at full, head order kept
        for (int i = 0; i < 4; i++) begin
            pushController({32'h5000_0000 | 32'(i), 32'h6000_0000 | 32'(i)});
        end
        checkOutput("rx_full", {63'd0, full1}, 64'd1);
        checkOutput("rx_wready_low", {63'd0, wready1}, 64'd0);
        checkOutput("rx_rvalid_tied", {63'd0, rvalid1}, 64'd0);
        applyStimulus(1, 1'b0, 32'h0);
        checkOutput("rx_full_rd0", {32'd0, rdata1}, 64'h6000_0000);
        applyStimulus(1, 1'b0, 32'h0);
        checkOutput("rx_full_rd1", {32'd0, rdata1}, 64'h5000_0000);
        checkOutput("rx_wready_back", {63'd0, wready1}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
